// File: rtl/lap_record_reader.sv
// Lap record FIFO with an ASCII "HH:MM:SS.CC" streamer toward the LCD character writer.
// The oldest record is popped into a private copy so later writes cannot disturb a stream.
module lap_record_reader #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             wr_en_i,
    input  logic [31:0]      wr_data_i,
    input  logic             clear_i,
    input  logic             rd_start_i,
    output logic [7:0]       char_o,
    output logic             char_valid_o,
    input  logic             char_ready_i,
    output logic             frame_end_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [3:0] LAST_IDX = 4'd10;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail_next;
    logic [CNT_W-1:0] count_next;
    logic [31:0]      rec;
    logic [31:0]      rec_next;
    logic [3:0]       idx;
    logic [3:0]       idx_next;
    logic [7:0]       char_next;
    logic             valid_next;
    logic             busy_next;
    logic             frame_next;
    logic             pop;
    logic             is_full;
    logic             flush;

    // BCD digits outside 0-9 are shown as '?' rather than garbage glyphs.
    function automatic logic [7:0] ascii_digit(input logic [3:0] nib);
        logic [7:0] ch;
        if (nib <= 4'd9) begin
            ch = 8'h30 + {4'h0, nib};
        end else begin
            ch = 8'h3F;
        end
        return ch;
    endfunction

    function automatic logic [7:0] char_at(input logic [31:0] r, input logic [3:0] i);
        logic [7:0] ch;
        case (i)
            4'd0:    ch = ascii_digit(r[31:28]);
            4'd1:    ch = ascii_digit(r[27:24]);
            4'd2:    ch = 8'h3A;
            4'd3:    ch = ascii_digit(r[23:20]);
            4'd4:    ch = ascii_digit(r[19:16]);
            4'd5:    ch = 8'h3A;
            4'd6:    ch = ascii_digit(r[15:12]);
            4'd7:    ch = ascii_digit(r[11:8]);
            4'd8:    ch = 8'h2E;
            4'd9:    ch = ascii_digit(r[7:4]);
            4'd10:   ch = ascii_digit(r[3:0]);
            default: ch = 8'h00;
        endcase
        return ch;
    endfunction

    assign is_full = (count_o == CNT_W'(DEPTH));
    assign flush   = reset_i | clear_i;

    always_comb begin
        state_next = state;
        rec_next   = rec;
        idx_next   = idx;
        char_next  = char_o;
        valid_next = char_valid_o;
        busy_next  = busy_o;
        frame_next = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (rd_start_i && !empty_o) begin
                    pop        = 1'b1;
                    rec_next   = mem[head];
                    idx_next   = 4'd0;
                    char_next  = char_at(mem[head], 4'd0);
                    valid_next = 1'b1;
                    busy_next  = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (char_ready_i) begin
                    if (idx == LAST_IDX) begin
                        frame_next = 1'b1;
                        valid_next = 1'b0;
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        idx_next  = idx + 4'd1;
                        char_next = char_at(rec, idx + 4'd1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A write into a full buffer drops the oldest entry, unless a pop already consumed it.
    always_comb begin
        head_next  = head;
        tail_next  = tail;
        count_next = count_o;
        if (pop || (wr_en_i && is_full)) begin
            head_next = head + 1'b1;
        end
        if (wr_en_i) begin
            tail_next = tail + 1'b1;
        end
        case ({wr_en_i, pop})
            2'b10:   count_next = is_full ? count_o : count_o + CNT_W'(1);
            2'b01:   count_next = count_o - CNT_W'(1);
            default: count_next = count_o;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (flush) begin
            state        <= IDLE;
            head         <= '0;
            tail         <= '0;
            count_o      <= '0;
            full_o       <= 1'b0;
            empty_o      <= 1'b1;
            rec          <= '0;
            idx          <= '0;
            char_o       <= 8'h00;
            char_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            frame_end_o  <= 1'b0;
        end else begin
            state        <= state_next;
            head         <= head_next;
            tail         <= tail_next;
            count_o      <= count_next;
            full_o       <= (count_next == CNT_W'(DEPTH));
            empty_o      <= (count_next == '0);
            rec          <= rec_next;
            idx          <= idx_next;
            char_o       <= char_next;
            char_valid_o <= valid_next;
            busy_o       <= busy_next;
            frame_end_o  <= frame_next;
        end
    end

    // Storage has no reset; stale contents are unreachable once the pointers are cleared.
    always_ff @(posedge clock_i) begin
        if (!flush && wr_en_i) begin
            mem[tail] <= wr_data_i;
        end
    end

endmodule
